// File: rtl/muldiv_seq_ctrl.sv
// Sequential unsigned multiply (shift-add) / divide (restoring) engine with a start/busy/done handshake.
// Result after WIDTH+1 cycles (1 cycle for divide-by-zero); start is accepted only in IDLE, with no queueing.
module muldiv_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [CW-1:0]    step_q
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_opb;
    logic             r_op_div;
    logic [CW-1:0]    r_step;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [1:0]       w_diff_hi;
    logic [WIDTH-1:0] w_diff_lo;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_mq_nx;

    // A non-negative difference is always below the divisor, so its top two bits are zero.
    always_comb begin
        w_sum                  = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opb} : '0);
        w_rem_sh               = {r_acc, r_mq[WIDTH-1]};
        {w_diff_hi, w_diff_lo} = {1'b0, w_rem_sh} - {2'b00, r_opb};
        w_q_bit                = (w_diff_hi == 2'b00);
        if (r_op_div) begin
            w_acc_nx = w_q_bit ? w_diff_lo : w_rem_sh[WIDTH-1:0];
            w_mq_nx  = {r_mq[WIDTH-2:0], w_q_bit};
        end else begin
            w_acc_nx = w_sum[WIDTH:1];
            w_mq_nx  = {w_sum[0], r_mq[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mq     <= '0;
            r_opb    <= '0;
            r_op_div <= 1'b0;
            r_step   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (op_div && (b == '0)) begin
                            r_res_lo <= '1;
                            r_res_hi <= a;
                            r_dbz    <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_acc    <= '0;
                            r_mq     <= a;
                            r_opb    <= b;
                            r_op_div <= op_div;
                            r_step   <= CW'(WIDTH - 1);
                            r_busy   <= 1'b1;
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        r_step  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_step == '0) begin
                        r_res_hi <= w_acc_nx;
                        r_res_lo <= w_mq_nx;
                        r_dbz    <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_acc  <= w_acc_nx;
                        r_mq   <= w_mq_nx;
                        r_step <= r_step - 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign result_lo   = r_res_lo;
    assign result_hi   = r_res_hi;
    assign step_q      = r_step;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Scoreboard bench: WIDTH=8 instance for directed cases, WIDTH=16 instance for random operands.
module tb_muldiv_seq_ctrl;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dbz;
        int          start_cyc;
        int          lat;
        int          busy_n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // WIDTH=8 instance
    logic       rst8 = 1'b1, start8 = 1'b0, op8 = 1'b0, abort8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, dbz8;
    logic [7:0] lo8, hi8;
    logic [2:0] step8;

    muldiv_seq_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst8), .start(start8), .op_div(op8), .abort(abort8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .div_by_zero(dbz8),
        .result_lo(lo8), .result_hi(hi8), .step_q(step8)
    );

    // WIDTH=16 instance
    logic        rst16 = 1'b1, start16 = 1'b0, op16 = 1'b0, abort16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, dbz16;
    logic [15:0] lo16, hi16;
    logic [3:0]  step16;

    muldiv_seq_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(rst16), .start(start16), .op_div(op16), .abort(abort16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .div_by_zero(dbz16),
        .result_lo(lo16), .result_hi(hi16), .step_q(step16)
    );

    exp_t q8[$];
    exp_t q16[$];
    int   ndone8 = 0, ndone16 = 0;
    int   bcnt8 = 0, bcnt16 = 0;
    exp_t e8, e16;

    always @(negedge clk) begin
        if (start8 && !busy8 && !done8) bcnt8 = 0;
        if (busy8) bcnt8++;
        if (done8) begin
            ndone8++;
            if (q8.size() == 0) begin
                chk("unexpected_done8", 1, 0);
            end else begin
                e8 = q8.pop_front();
                chk("lo8", 32'(lo8), 32'(e8.lo));
                chk("hi8", 32'(hi8), 32'(e8.hi));
                chk("dbz8", 32'(dbz8), 32'(e8.dbz));
                chk("lat8", cyc - e8.start_cyc, e8.lat);
                chk("busy_cycles8", bcnt8, e8.busy_n);
                chk("busy_with_done8", 32'(busy8), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (start16 && !busy16 && !done16) bcnt16 = 0;
        if (busy16) bcnt16++;
        if (done16) begin
            ndone16++;
            if (q16.size() == 0) begin
                chk("unexpected_done16", 1, 0);
            end else begin
                e16 = q16.pop_front();
                chk("lo16", 32'(lo16), 32'(e16.lo));
                chk("hi16", 32'(hi16), 32'(e16.hi));
                chk("dbz16", 32'(dbz16), 32'(e16.dbz));
                chk("lat16", cyc - e16.start_cyc, e16.lat);
                chk("busy_cycles16", bcnt16, e16.busy_n);
                chk("busy_with_done16", 32'(busy16), 0);
            end
        end
    end

    // Drives one start pulse; optionally records the arithmetic reference.
    task automatic drive(input bit w16, input logic dv, input logic [15:0] aa,
                         input logic [15:0] bb, input bit push);
        exp_t        e;
        logic [31:0] p;
        int          w;
        w = w16 ? 16 : 8;
        @(posedge clk); #1;
        if (w16) begin
            start16 = 1'b1; op16 = dv; a16 = aa; b16 = bb;
        end else begin
            start8 = 1'b1; op8 = dv; a8 = aa[7:0]; b8 = bb[7:0];
        end
        e.start_cyc = cyc;
        e.lat       = w + 1;
        e.busy_n    = w;
        e.dbz       = 1'b0;
        if (!dv) begin
            p    = {16'h0, aa} * {16'h0, bb};
            e.lo = w16 ? p[15:0] : {8'h0, p[7:0]};
            e.hi = w16 ? p[31:16] : {8'h0, p[15:8]};
        end else if (bb == 16'h0) begin
            e.lo     = w16 ? 16'hFFFF : 16'h00FF;
            e.hi     = aa;
            e.dbz    = 1'b1;
            e.lat    = 1;
            e.busy_n = 0;
        end else begin
            e.lo = aa / bb;
            e.hi = aa % bb;
        end
        if (push) begin
            if (w16) q16.push_back(e);
            else     q8.push_back(e);
        end
        @(posedge clk); #1;
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic wait_done(input bit w16, input int n0);
        int k;
        k = 0;
        while (((w16 ? ndone16 : ndone8) == n0) && (k < 40)) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 40) chk(w16 ? "timeout16" : "timeout8", 0, 1);
    endtask

    task automatic run(input bit w16, input logic dv, input logic [15:0] aa, input logic [15:0] bb);
        int n0;
        n0 = w16 ? ndone16 : ndone8;
        drive(w16, dv, aa, bb, 1'b1);
        wait_done(w16, n0);
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b0; rst16 = 1'b0;
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_dbz8", 32'(dbz8), 0);
        chk("rst_res8", {16'h0, hi8, lo8}, 0);
        chk("rst_step8", 32'(step8), 0);
        chk("rst_res16", {hi16, lo16}, 0);
        chk("rst_busy16", 32'(busy16), 0);

        run(1'b0, 1'b0, 16'd13, 16'd11);

        // Abort: start in cycle t, abort sampled in cycle t+4, IDLE in t+5.
        drive(1'b0, 1'b0, 16'd3, 16'd3, 1'b0);
        chk("calc_busy8", 32'(busy8), 1);
        chk("calc_step_first8", 32'(step8), 7);
        repeat (3) @(posedge clk);
        #1; abort8 = 1'b1;
        @(posedge clk); #1; abort8 = 1'b0;
        chk("abort_busy8", 32'(busy8), 0);
        chk("abort_step8", 32'(step8), 0);
        chk("abort_done8", 32'(done8), 0);
        chk("abort_lo8", 32'(lo8), 32'h8F);
        chk("abort_hi8", 32'(hi8), 32'h00);
        repeat (15) @(posedge clk);

        run(1'b0, 1'b0, 16'hFF, 16'hFF);
        run(1'b0, 1'b1, 16'd200, 16'd7);
        run(1'b0, 1'b1, 16'd5, 16'd0);
        run(1'b0, 1'b0, 16'd2, 16'd3);
        run(1'b0, 1'b1, 16'd250, 16'd200);
        run(1'b0, 1'b1, 16'd255, 16'd255);
        run(1'b0, 1'b1, 16'd3, 16'd200);
        run(1'b0, 1'b0, 16'd0, 16'd77);

        // A start pulse during CALC must be ignored.
        n0 = ndone8;
        drive(1'b0, 1'b0, 16'd5, 16'd6, 1'b1);
        @(posedge clk); #1;
        start8 = 1'b1; op8 = 1'b1; a8 = 8'd1; b8 = 8'd0;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done(1'b0, n0);
        repeat (12) @(posedge clk);

        // Reset in mid-CALC loses the operation.
        drive(1'b0, 1'b0, 16'd7, 16'd9, 1'b0);
        repeat (2) @(posedge clk);
        #1; rst8 = 1'b1;
        @(posedge clk); #1; rst8 = 1'b0;
        chk("midrst_busy8", 32'(busy8), 0);
        chk("midrst_step8", 32'(step8), 0);
        chk("midrst_res8", {16'h0, hi8, lo8}, 0);
        chk("midrst_dbz8", 32'(dbz8), 0);
        repeat (15) @(posedge clk);

        for (int i = 0; i < 1000; i++) begin
            logic        dv;
            logic [15:0] aa, bb;
            dv = 1'($urandom_range(0, 1));
            aa = 16'($urandom_range(0, 65535));
            bb = dv ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(0, 65535));
            if (i == 0) begin dv = 1'b0; aa = 16'hFFFF; bb = 16'hFFFF; end
            if (i == 1) begin dv = 1'b1; aa = 16'hFFFF; bb = 16'h8001; end
            if (i == 2) begin dv = 1'b1; aa = 16'h1234; bb = 16'h0001; end
            run(1'b1, dv, aa, bb);
        end

        repeat (5) @(posedge clk);
        chk("queue8_empty", q8.size(), 0);
        chk("queue16_empty", q16.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_seq_ctrl.md
# muldiv_seq_ctrl

Parametrised sequencer and datapath for multi-cycle unsigned multiply and divide in the A5 execution stage. It supersedes the fixed MUL-phase sequencing with a generic WIDTH-bit engine. One engine performs shift-add multiplication or restoring division and uses a step counter sized from WIDTH. It also adds an explicit start/busy/done handshake, a divide-by-zero fast path and an abort input. The top-level state machine starts it on a MUL/DIV opcode and stalls on `busy`.

## Interface
- `WIDTH`, default 8, operand width in bits. WIDTH ≥ 2 and a power of two.
- `CW`, default `$clog2(WIDTH)`, step-counter width. Derived; never overridden.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a new operation. Sampled only in IDLE.
- `op_div`  in  1  0 = multiply, 1 = divide. Sampled with `start`.
- `abort`  in  1  cancel an operation in progress (effective in CALC only).
- `a`  in  WIDTH  multiplicand or dividend. Sampled with `start`.
- `b`  in  WIDTH  multiplier or divisor. Sampled with `start`.
- `busy`  out  1  high in CALC.
- `done`  out  1  one-cycle pulse in DONE.
- `div_by_zero`  out  1  status flag for the last completed operation.
- `result_lo`  out  WIDTH  MUL: low half of product. DIV: quotient.
- `result_hi`  out  WIDTH  MUL: high half of product. DIV: remainder.
- `step_q`  out  CW  current step counter, for debug and the top FSM.

## Operation
- States: IDLE, CALC, DONE. Encoding is free; the state register is not exported.
- IDLE, `start`=1, not (`op_div` & `b`==0):
  - latch `a`, `b`, `op_div` into working registers;
  - clear the accumulator;
  - `step_q` ← WIDTH−1;
  - go to CALC.
- IDLE, `start`=1, `op_div`=1, `b`==0:
  - `result_lo` ← all ones, `result_hi` ← `a`, `div_by_zero` ← 1;
  - go to DONE.
- IDLE, `start`=0: stay in IDLE.
- CALC performs one iteration per cycle.
  - MUL: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half with a WIDTH+1-bit carry. Then shift {carry, acc, multiplier} right by 1.
  - DIV (restoring): shift {rem, dividend} left by 1. Compute rem−divisor in WIDTH+1 bits. If it is non-negative, rem ← difference and the quotient bit is 1; otherwise the quotient bit is 0.
- CALC, `step_q`==0 (last iteration):
  - `result_hi`/`result_lo` ← final values from this iteration's combinational result;
  - `div_by_zero` ← 0;
  - go to DONE.
- CALC, otherwise: `step_q` decrements by 1 and the FSM stays in CALC.
- CALC, `abort`=1 (priority over the step-0 transition): go to IDLE. Results, `div_by_zero` and `done` are unchanged. `step_q` ← 0.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. `start` in DONE is ignored.
- `start` in CALC or DONE is ignored and not queued.
- Arithmetic is unsigned only.
  - MUL: {`result_hi`,`result_lo`} = a·b exactly, 2·WIDTH bits.
  - DIV: a = `result_lo`·b + `result_hi`, with `result_hi` < b.
- Result registers change only on the edge entering DONE. They hold stable at all other times, including during the next CALC.

## Timing
- Reset (synchronous, on a rising edge with `reset`=1), which overrides `start` and `abort`:
  - state IDLE;
  - `busy`=0, `done`=0, `div_by_zero`=0;
  - `result_lo`=0, `result_hi`=0, `step_q`=0.
- Reset mid-CALC: the operation is lost and there is no `done` pulse.
- Normal operation:
  - `start` is sampled high in cycle t;
  - `busy` is high in cycles t+1 … t+WIDTH, with `step_q` = WIDTH−1 … 0;
  - `done` and valid results appear in cycle t+WIDTH+1.
- Divide-by-zero: `start` in cycle t gives `done` in cycle t+1; `busy` never rises.
- Back-to-back: the earliest next accepted `start` is in cycle t+WIDTH+2 (IDLE).
- `busy` and `done` are never high together. All outputs are registered.

## Test plan
- WIDTH=8, MUL a=13 b=11 → `busy` for 8 cycles, then `done` at t+9 with `result_hi`=0x00, `result_lo`=0x8F, `div_by_zero`=0.
- WIDTH=8, MUL a=0xFF b=0xFF → `result_hi`=0xFE, `result_lo`=0x01. Then DIV a=200 b=7 → `result_lo`=28 (0x1C), `result_hi`=4.
- WIDTH=8, DIV a=5 b=0 → `done` at t+1, `busy` stays 0, `result_lo`=0xFF, `result_hi`=0x05, `div_by_zero`=1. A following MUL 2·3 clears `div_by_zero` and gives `result_lo`=6.
- MUL 13·11 completes, then MUL 3·3 with `abort` at cycle t+4 → FSM returns to IDLE at t+5, no `done` pulse, results remain 0x00/0x8F. A `start` pulsed during CALC of another operation is ignored, and that operation's result is unaffected.
- `reset` asserted in mid-CALC → next cycle `busy`=0, `step_q`=0, results 0, and no `done` afterwards.
- WIDTH=16, random 1000 operands, MUL and DIV with b≠0 → results match the arithmetic reference, and latency is exactly 17 cycles.
